// File: rtl/seven_seg_ctrl_pkg.sv
// Shared types and constants for the seven-segment display controller:
// arbiter state encoding, debug view and the default scan prescale.
package seven_seg_ctrl_pkg;

  localparam int          DATA_W           = 16;
  localparam logic [15:0] PRESCALE_DEFAULT = 16'd50000;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERVE0 = 2'd1,
    SERVE1 = 2'd2
  } arb_state_t;

  typedef struct packed {
    arb_state_t state;
    logic       tick;
    logic       pending;
    logic       last_grant;
  } dbg_t;

  // Active-low digit enable with only the scanned position pulled low.
  function automatic logic [3:0] an_for_idx(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/seven_seg_ctrl_if.sv
// Write-request bundle for the two display requesters (CPU = port 0, debug = port 1).
// Handshake: a requester holds reqk_valid/reqk_data; reqk_ready is high for exactly one
// cycle when the arbiter serves port k, and the data is taken on that edge only if
// reqk_valid is still high. Ready never depends on valid within the same cycle.
interface seven_seg_ctrl_if;

  logic                                  req0_valid;
  logic [seven_seg_ctrl_pkg::DATA_W-1:0] req0_data;
  logic                                  req0_ready;
  logic                                  req1_valid;
  logic [seven_seg_ctrl_pkg::DATA_W-1:0] req1_data;
  logic                                  req1_ready;

  modport master (
    output req0_valid, req0_data, req1_valid, req1_data,
    input  req0_ready, req1_ready
  );

  modport slave (
    input  req0_valid, req0_data, req1_valid, req1_data,
    output req0_ready, req1_ready
  );

endinterface

// File: rtl/seven_seg_ctrl_scan_timer.sv
// Digit scan timing: prescaler producing a tick every PRESCALE clocks and a
// 2-bit scan index advanced by that tick; frame_done marks the 3 -> 0 wrap.
module scan_timer
  import seven_seg_ctrl_pkg::*;
#(
  parameter logic [15:0] PRESCALE = PRESCALE_DEFAULT
) (
  input  logic       clk,
  input  logic       reset,
  output logic       tick,
  output logic [1:0] idx,
  output logic       frame_done
);

  logic [15:0] r_count;
  logic [1:0]  r_idx;
  logic        w_tick;

  assign w_tick = (r_count == (PRESCALE - 16'd1));

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_count <= 16'd0;
      r_idx   <= 2'd0;
    end else if (w_tick) begin
      r_count <= 16'd0;
      r_idx   <= r_idx + 2'd1;
    end else begin
      r_count <= r_count + 16'd1;
    end
  end

  assign tick       = w_tick;
  assign idx        = r_idx;
  assign frame_done = w_tick && (r_idx == 2'd3);

endmodule

// File: rtl/seven_seg_ctrl.sv
// Four-digit multiplexed seven-segment controller: two requesters write a shadow
// value through a fair arbiter; the shown value only changes at frame boundaries.
module seven_seg_ctrl
  import seven_seg_ctrl_pkg::*;
#(
  parameter logic [15:0] PRESCALE = PRESCALE_DEFAULT
) (
  input  logic            clk,
  input  logic            reset,
  seven_seg_ctrl_if.slave bus,
  input  logic            lz_blank,
  output logic [3:0]      digit,
  output logic [3:0]      an,
  output logic            frame_done,
  output dbg_t            o_dbg
);

  arb_state_t  r_state;
  arb_state_t  w_next_state;
  logic        r_last_grant;
  logic        r_pending;
  logic [15:0] r_shadow;
  logic [15:0] r_active;

  logic        w_tick;
  logic [1:0]  w_idx;
  logic        w_frame_done;
  logic        w_ready0;
  logic        w_ready1;
  logic        w_cap0;
  logic        w_cap1;
  logic [3:0]  w_nibble;
  logic        w_upper_zero;

  scan_timer #(
    .PRESCALE (PRESCALE)
  ) u_scan_timer (
    .clk        (clk),
    .reset      (reset),
    .tick       (w_tick),
    .idx        (w_idx),
    .frame_done (w_frame_done)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // On simultaneous requests the port that did not win last time goes first.
  always_comb begin
    w_next_state = r_state;
    case (r_state)
      IDLE: begin
        if (bus.req0_valid && bus.req1_valid) begin
          w_next_state = r_last_grant ? SERVE0 : SERVE1;
        end else if (bus.req0_valid) begin
          w_next_state = SERVE0;
        end else if (bus.req1_valid) begin
          w_next_state = SERVE1;
        end else begin
          w_next_state = IDLE;
        end
      end
      SERVE0:  w_next_state = IDLE;
      SERVE1:  w_next_state = IDLE;
      default: w_next_state = IDLE;
    endcase
  end

  always_comb begin
    w_ready0 = (r_state == SERVE0);
    w_ready1 = (r_state == SERVE1);
    w_cap0   = w_ready0 && bus.req0_valid;
    w_cap1   = w_ready1 && bus.req1_valid;
  end

  assign bus.req0_ready = w_ready0;
  assign bus.req1_ready = w_ready1;

  // Active takes the old shadow before a same-cycle capture overwrites it,
  // so a capture on the boundary stays pending for the following frame.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_last_grant <= 1'b1;
      r_pending    <= 1'b0;
      r_shadow     <= 16'h0000;
      r_active     <= 16'h0000;
    end else begin
      if (w_frame_done && r_pending) begin
        r_active <= r_shadow;
      end
      if (w_cap0) begin
        r_shadow     <= bus.req0_data;
        r_last_grant <= 1'b0;
      end else if (w_cap1) begin
        r_shadow     <= bus.req1_data;
        r_last_grant <= 1'b1;
      end
      if (w_cap0 || w_cap1) begin
        r_pending <= 1'b1;
      end else if (w_frame_done) begin
        r_pending <= 1'b0;
      end
    end
  end

  always_comb begin
    w_nibble     = r_active[3:0];
    w_upper_zero = 1'b0;
    case (w_idx)
      2'd0: begin
        w_nibble     = r_active[3:0];
        w_upper_zero = 1'b0;
      end
      2'd1: begin
        w_nibble     = r_active[7:4];
        w_upper_zero = (r_active[15:4] == 12'h000);
      end
      2'd2: begin
        w_nibble     = r_active[11:8];
        w_upper_zero = (r_active[15:8] == 8'h00);
      end
      default: begin
        w_nibble     = r_active[15:12];
        w_upper_zero = (r_active[15:12] == 4'h0);
      end
    endcase
  end

  assign digit      = w_nibble;
  assign an         = (lz_blank && w_upper_zero) ? 4'b1111 : an_for_idx(w_idx);
  assign frame_done = w_frame_done;

  always_comb begin
    o_dbg.state      = r_state;
    o_dbg.tick       = w_tick;
    o_dbg.pending    = r_pending;
    o_dbg.last_grant = r_last_grant;
  end

endmodule

// File: tb/tb_seven_seg_ctrl.sv
// Directed and randomized checks of seven_seg_ctrl against a cycle-level reference
// model built from the display/arbitration rules with plain integer arithmetic.
module tb_seven_seg_ctrl;
  import seven_seg_ctrl_pkg::*;

  localparam int P = 4;

  logic clk = 1'b0;
  logic reset;
  logic lz_blank;

  logic [3:0] digit, an, digit1, an1;
  logic       frame_done, frame_done1;
  dbg_t       dbg, dbg1;

  seven_seg_ctrl_if bus ();
  seven_seg_ctrl_if bus1 ();

  always #5 clk = ~clk;

  seven_seg_ctrl #(.PRESCALE(16'd4)) dut (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus.slave),
    .lz_blank   (lz_blank),
    .digit      (digit),
    .an         (an),
    .frame_done (frame_done),
    .o_dbg      (dbg)
  );

  seven_seg_ctrl #(.PRESCALE(16'd1)) dut_p1 (
    .clk        (clk),
    .reset      (reset),
    .bus        (bus1.slave),
    .lz_blank   (1'b0),
    .digit      (digit1),
    .an         (an1),
    .frame_done (frame_done1),
    .o_dbg      (dbg1)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  int          m_k;
  int          m_serve;
  int          m_last;
  bit          m_pending;
  logic [15:0] m_shadow;
  logic [15:0] m_active;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h (k=%0d t=%0t)", tag, obs, exp, m_k, $time);
    end
  endtask

  task automatic model_reset();
    m_k       = 0;
    m_serve   = 0;
    m_last    = 1;
    m_pending = 0;
    m_shadow  = 16'h0000;
    m_active  = 16'h0000;
  endtask

  task automatic check_now();
    int   idx, idx1, upper, nib, exp_an, exp_fd, exp_tick;
    idx      = (m_k / P) % 4;
    exp_fd   = ((m_k % (4 * P)) == (4 * P - 1)) ? 1 : 0;
    exp_tick = ((m_k % P) == (P - 1)) ? 1 : 0;
    upper    = int'(m_active) >> (4 * idx);
    nib      = upper % 16;
    exp_an   = (lz_blank && idx > 0 && upper == 0) ? 15 : (15 - (1 << idx));
    chk("ready0",     32'(bus.req0_ready),  32'(m_serve == 1));
    chk("ready1",     32'(bus.req1_ready),  32'(m_serve == 2));
    chk("frame_done", 32'(frame_done),      32'(exp_fd));
    chk("tick",       32'(dbg.tick),        32'(exp_tick));
    chk("digit",      32'(digit),           32'(nib));
    chk("an",         32'(an),              32'(exp_an));
    chk("state",      32'(dbg.state),       32'(m_serve));
    chk("pending",    32'(dbg.pending),     32'(m_pending));
    chk("last_grant", 32'(dbg.last_grant),  32'(m_last));
    idx1 = m_k % 4;
    chk("p1_an",         32'(an1),         32'(15 - (1 << idx1)));
    chk("p1_frame_done", 32'(frame_done1), 32'(idx1 == 3));
    chk("p1_tick",       32'(dbg1.tick),   32'd1);
  endtask

  task automatic model_edge(input bit v0, input bit v1, input logic [15:0] d0,
                            input logic [15:0] d1);
    bit fd;
    fd = ((m_k % (4 * P)) == (4 * P - 1));
    if (fd && m_pending) begin
      m_active  = m_shadow;
      m_pending = 0;
    end
    if (m_serve == 1 && v0) begin
      m_shadow  = d0;
      m_pending = 1;
      m_last    = 0;
    end else if (m_serve == 2 && v1) begin
      m_shadow  = d1;
      m_pending = 1;
      m_last    = 1;
    end
    if (m_serve != 0)  m_serve = 0;
    else if (v0 && v1) m_serve = (m_last == 0) ? 2 : 1;
    else if (v0)       m_serve = 1;
    else if (v1)       m_serve = 2;
    m_k++;
  endtask

  // Called at a falling edge with inputs already driven; returns at the next falling edge.
  task automatic cycle();
    bit          v0, v1;
    logic [15:0] d0, d1;
    #1;
    check_now();
    v0 = bus.req0_valid;
    v1 = bus.req1_valid;
    d0 = bus.req0_data;
    d1 = bus.req1_data;
    @(posedge clk);
    model_edge(v0, v1, d0, d1);
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) cycle();
  endtask

  task automatic set_req(input bit v0, input logic [15:0] d0, input bit v1,
                         input logic [15:0] d1);
    bus.req0_valid = v0;
    bus.req0_data  = d0;
    bus.req1_valid = v1;
    bus.req1_data  = d1;
  endtask

  task automatic apply_reset();
    reset = 1'b0;
    #1;
    model_reset();
    check_now();
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
  endtask

  initial begin
    reset          = 1'b1;
    lz_blank       = 1'b0;
    bus1.req0_valid = 1'b0;
    bus1.req0_data  = 16'h0;
    bus1.req1_valid = 1'b0;
    bus1.req1_data  = 16'h0;
    set_req(1'b0, 16'h0, 1'b0, 16'h0);
    model_reset();
    @(negedge clk);

    // Free-running scan with no requests.
    apply_reset();
    run(40);

    // Both requesters valid straight out of reset.
    apply_reset();
    set_req(1'b1, 16'h1234, 1'b1, 16'hABCD);
    run(4);
    set_req(1'b0, 16'h0, 1'b0, 16'h0);
    run(36);

    // Leading-zero blanking of 16'h00A5.
    lz_blank = 1'b1;
    set_req(1'b1, 16'h00A5, 1'b0, 16'h0);
    run(2);
    set_req(1'b0, 16'h0, 1'b0, 16'h0);
    run(40);
    lz_blank = 1'b0;

    // Debug requester drops valid while being served; fairness is unaffected.
    apply_reset();
    set_req(1'b0, 16'h0, 1'b1, 16'h7777);
    run(1);
    set_req(1'b0, 16'h0, 1'b0, 16'h7777);
    run(2);
    set_req(1'b1, 16'h2468, 1'b1, 16'h1357);
    run(4);
    set_req(1'b0, 16'h0, 1'b0, 16'h0);
    run(36);

    // Capture landing exactly on the frame boundary while an older value is pending.
    apply_reset();
    set_req(1'b1, 16'h1111, 1'b0, 16'h0);
    run(2);
    set_req(1'b0, 16'h0, 1'b0, 16'h0);
    for (int i = 0; i < 32; i++) begin
      if ((m_k % (4 * P)) == (4 * P - 2) && m_serve == 0) break;
      cycle();
    end
    set_req(1'b1, 16'h5555, 1'b0, 16'h0);
    run(2);
    set_req(1'b0, 16'h0, 1'b0, 16'h0);
    run(40);

    // Reset asserted in the middle of a SERVE0 cycle.
    apply_reset();
    lz_blank = 1'b1;
    set_req(1'b1, 16'hBEEF, 1'b0, 16'h0);
    run(1);
    #1;
    check_now();
    #1;
    reset = 1'b0;
    #1;
    model_reset();
    check_now();
    set_req(1'b0, 16'h0, 1'b0, 16'h0);
    @(posedge clk);
    @(negedge clk);
    reset = 1'b1;
    run(40);

    // Randomized traffic.
    for (int i = 0; i < 800; i++) begin
      if (i % 50 == 0) lz_blank = 1'($urandom_range(0, 1));
      set_req(($urandom_range(0, 3) == 0), 16'($urandom),
              ($urandom_range(0, 3) == 0), 16'($urandom));
      if (($urandom_range(0, 1)) == 1) begin
        bus.req0_data = {8'h00, 4'($urandom), 4'($urandom)};
      end
      cycle();
    end
    set_req(1'b0, 16'h0, 1'b0, 16'h0);
    run(32);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule

// File: doc/seven_seg_ctrl.md
SEVEN_SEG_CTRL -- requirements
Module: seven_seg_ctrl

Interface
REQ-001 SHALL have parameter PRESCALE, default 16'd50000, meaning clk cycles per digit-advance tick (legal range 1..65535).
REQ-002 SHALL have port clk, input, 1, the single clock; all state on rising edge.
REQ-003 SHALL have port reset, input, 1, asynchronous active-low reset.
REQ-004 SHALL have ports req0_valid / req1_valid, input, 1 each, display-write request from requester 0 (CPU) / 1 (debug).
REQ-005 SHALL have ports req0_data / req1_data, input, 16 each, requested display value.
REQ-006 SHALL have ports req0_ready / req1_ready, output, 1 each, write accepted this cycle.
REQ-007 SHALL have port lz_blank, input, 1, leading-zero blanking enable.
REQ-008 SHALL have port digit, output, 4, nibble of the currently scanned digit.
REQ-009 SHALL have port an, output, 4, active-low digit enables, at most one bit low.
REQ-010 SHALL have port frame_done, output, 1, one-cycle pulse when the scan wraps digit 3 -> 0.

Function
REQ-011 Prescaler: counter 0..PRESCALE-1; tick asserted the cycle count == PRESCALE-1, count then returns to 0; PRESCALE=1 ticks every cycle.
REQ-012 Scan index idx (2 bits): increments on tick, wraps 3 -> 0; frame_done = tick AND idx==3.
REQ-013 digit = nibble idx of the active register (idx 0 = bits 3:0 ... idx 3 = bits 15:12); an = all ones except an[idx]=0, unless blanked.
REQ-014 Blanking: when lz_blank=1, digit i (i=1..3) is blanked (an all ones) if nibbles i..3 are all zero; digit 0 is never blanked.
REQ-015 Arbiter FSM states IDLE, SERVE0, SERVE1.
REQ-016 IDLE: req0_valid only -> SERVE0; req1_valid only -> SERVE1; both -> port not equal to last_grant; none -> stay.
REQ-017 SERVEk: reqk_ready=1 combinationally from state for exactly one cycle; if reqk_valid=1 at that edge, reqk_data is captured into the shadow register, pending is set, last_grant <= k; next state IDLE unconditionally.
REQ-018 A requester dropping valid while in SERVEk causes no capture and no last_grant update; ready still pulses.
REQ-019 Ready latency: valid first seen in IDLE at cycle N -> ready at cycle N+1; a continuously held valid is accepted at most once per 2 cycles.
REQ-020 Active register loads from shadow only on the frame_done cycle while pending=1; pending clears on that cycle, so displayed value never changes mid-frame.
REQ-021 Capture and frame_done in the same cycle: the old shadow value loads into active, new data lands in shadow, pending stays 1.
REQ-022 Two captures before a frame boundary: the later value wins; earlier value is never displayed.

Reset
REQ-023 On reset low: prescaler 0, idx 0, state IDLE, last_grant 1, pending 0, shadow 16'h0000, active 16'h0000.
REQ-024 Outputs during reset: req0_ready=0, req1_ready=0, frame_done=0, digit=4'h0, an=4'b1110.
REQ-025 Reset asserted mid-SERVE discards the transaction; no capture occurs.

Structure
REQ-026 Shared package holds arbiter state encoding (IDLE=0, SERVE0=1, SERVE1=2) and the default PRESCALE constant.
REQ-027 Prescaler plus scan index SHALL be a sub-module named scan_timer (outputs tick, idx, frame_done); arbiter and registers stay in seven_seg_ctrl.

Verification
REQ-028 PRESCALE=4, no requests -> tick every 4 cycles, an sequence 1110,1101,1011,0111 repeating, frame_done every 16 cycles.
REQ-029 Both valid from reset with data 16'h1234 / 16'hABCD -> req0_ready first, req1_ready 2 cycles later; after the next frame_done, active = 16'hABCD.
REQ-030 req0_data=16'h00A5, lz_blank=1 -> digits 3,2 blanked (an=1111 at idx 3,2), idx 1 shows 4'hA, idx 0 shows 4'h5.
REQ-031 Capture 16'h5555 on the frame_done cycle with prior shadow 16'h1111 pending -> that frame boundary loads 16'h1111, the next loads 16'h5555.
REQ-032 req1_valid dropped in SERVE1 -> req1_ready pulses, shadow unchanged, next simultaneous request still grants port 0.
REQ-033 Reset pulsed low during SERVE0 -> all REQ-023/024 values within the same cycle, no capture.
